// File: rtl/dl_pkg.sv
// rtl/dl_pkg.sv - constant helpers for sizing the OR-reduction pipeline
package dl_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/dl_or.sv
// rtl/dl_or.sv - two-input bitwise OR primitive
module dl_or #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_a | i_b;

endmodule

// File: rtl/dl_or_stage.sv
// rtl/dl_or_stage.sv - one pipeline stage: NUM_LEVELS OR-tree levels feeding a valid/ready register slice
module dl_or_stage #(
    parameter int NUM_BITS   = 32,
    parameter int NUM_IN     = 2,
    parameter int NUM_LEVELS = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        i_valid,
    output logic                                        o_ready,
    input  logic [NUM_IN*NUM_BITS-1:0]                  i_data,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic [(NUM_IN >> NUM_LEVELS)*NUM_BITS-1:0]  o_data
);

    localparam int NUM_OUT = NUM_IN >> NUM_LEVELS;
    localparam int TREE_W  = NUM_BITS * (2*NUM_IN - NUM_OUT);

    // All tree levels are packed back to back in one vector; level j starts here.
    function automatic int lvl_off(input int j);
        return NUM_BITS * (2*NUM_IN - 2*(NUM_IN >> j));
    endfunction

    logic [TREE_W-1:0]           w_tree;
    logic [NUM_OUT*NUM_BITS-1:0] w_next;
    logic                        r_valid;
    logic [NUM_OUT*NUM_BITS-1:0] r_data;

    assign w_tree[0 +: NUM_IN*NUM_BITS] = i_data;

    generate
        for (genvar j = 1; j <= NUM_LEVELS; j++) begin : g_lvl
            for (genvar n = 0; n < (NUM_IN >> j); n++) begin : g_node
                dl_or #(.WIDTH(NUM_BITS)) u_or (
                    .i_a (w_tree[lvl_off(j-1) + (2*n)*NUM_BITS   +: NUM_BITS]),
                    .i_b (w_tree[lvl_off(j-1) + (2*n+1)*NUM_BITS +: NUM_BITS]),
                    .o_y (w_tree[lvl_off(j)   + n*NUM_BITS       +: NUM_BITS])
                );
            end
        end
    endgenerate

    assign w_next  = w_tree[lvl_off(NUM_LEVELS) +: NUM_OUT*NUM_BITS];
    // An empty slice accepts regardless of downstream, so bubbles collapse.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_next;
            end
        end
    end

endmodule

// File: rtl/dl_or_reduce_pipe.sv
// rtl/dl_or_reduce_pipe.sv - pipelined masked N-way OR reduction with sticky accumulator
module dl_or_reduce_pipe
    import dl_pkg::*;
#(
    parameter int NUM_BITS         = 32,
    parameter int NUM_INPUTS       = 8,
    parameter int LEVELS_PER_STAGE = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_INPUTS*NUM_BITS-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]          in_mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_BITS-1:0]            out_data,
    output logic                           out_any,
    input  logic                           acc_clr,
    output logic [NUM_BITS-1:0]            acc_data
);

    localparam int L          = clog2(NUM_INPUTS);
    localparam int P          = 1 << L;
    localparam int NUM_STAGES = (L == 0) ? 1 : ceil_div(L, LEVELS_PER_STAGE);

    // Operand count entering stage k (k == NUM_STAGES gives the single result).
    function automatic int stage_cnt(input int k);
        int d;
        d = k * LEVELS_PER_STAGE;
        if (d > L) d = L;
        return P >> d;
    endfunction

    // The last stage takes whatever levels remain.
    function automatic int stage_lvls(input int k);
        int r;
        r = L - k * LEVELS_PER_STAGE;
        if (r > LEVELS_PER_STAGE) r = LEVELS_PER_STAGE;
        if (r < 0) r = 0;
        return r;
    endfunction

    function automatic int bus_off(input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++) s = s + stage_cnt(i) * NUM_BITS;
        return s;
    endfunction

    localparam int BUS_W = bus_off(NUM_STAGES + 1);

    logic [P*NUM_BITS-1:0]   w_leaves;
    logic [BUS_W-1:0]        w_bus;
    logic [NUM_STAGES:0]     w_valid;
    logic [NUM_STAGES:0]     w_ready;
    logic                    w_out_fire;
    logic [NUM_BITS-1:0]     r_acc;

    // Masked operands and padding leaves are zero, the OR identity.
    always_comb begin
        w_leaves = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_mask[i]) begin
                w_leaves[i*NUM_BITS +: NUM_BITS] = in_data[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    assign w_bus[0 +: P*NUM_BITS] = w_leaves;
    assign w_valid[0]             = in_valid;
    assign in_ready               = w_ready[0];
    assign w_ready[NUM_STAGES]    = out_ready;

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            localparam int CNT_IN  = stage_cnt(k);
            localparam int CNT_OUT = stage_cnt(k + 1);
            localparam int LVLS    = stage_lvls(k);
            localparam int OFF_IN  = bus_off(k);
            localparam int OFF_OUT = bus_off(k + 1);

            dl_or_stage #(
                .NUM_BITS   (NUM_BITS),
                .NUM_IN     (CNT_IN),
                .NUM_LEVELS (LVLS)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (w_valid[k]),
                .o_ready (w_ready[k]),
                .i_data  (w_bus[OFF_IN +: CNT_IN*NUM_BITS]),
                .o_valid (w_valid[k+1]),
                .i_ready (w_ready[k+1]),
                .o_data  (w_bus[OFF_OUT +: CNT_OUT*NUM_BITS])
            );
        end
    endgenerate

    assign out_valid  = w_valid[NUM_STAGES];
    assign out_data   = w_bus[bus_off(NUM_STAGES) +: NUM_BITS];
    assign out_any    = |out_data;
    assign w_out_fire = out_valid && out_ready;
    assign acc_data   = r_acc;

    // A clear coinciding with a delivery restarts the accumulator from that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= w_out_fire ? out_data : '0;
        end else if (w_out_fire) begin
            r_acc <= r_acc | out_data;
        end
    end

endmodule

// File: tb/tb_dl_or_reduce_pipe.sv
// tb/tb_dl_or_reduce_pipe.sv - scoreboard bench for dl_or_reduce_pipe (4-input/1-level and 5-input/2-level)
module tb_dl_or_reduce_pipe;

    typedef struct {
        logic [7:0] data;
        int         fire_cyc;
        bit         chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic [3:0]  a_in_mask = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [7:0]  a_out_data;
    logic        a_out_any;
    logic        a_acc_clr = 1'b0;
    logic [7:0]  a_acc_data;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [39:0] b_in_data = '0;
    logic [4:0]  b_in_mask = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_out_data;
    logic        b_out_any;
    logic        b_acc_clr = 1'b0;
    logic [7:0]  b_acc_data;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        ea;
    exp_t        eb;
    int          n_acc_a = 0;
    bit          drv_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dl_or_reduce_pipe #(.NUM_BITS(8), .NUM_INPUTS(4), .LEVELS_PER_STAGE(1)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mask   (a_in_mask),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_any   (a_out_any),
        .acc_clr   (a_acc_clr),
        .acc_data  (a_acc_data)
    );

    dl_or_reduce_pipe #(.NUM_BITS(8), .NUM_INPUTS(5), .LEVELS_PER_STAGE(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mask   (b_in_mask),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_any   (b_out_any),
        .acc_clr   (b_acc_clr),
        .acc_data  (b_acc_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    task automatic send_a(input logic [31:0] d, input logic [3:0] m, input logic [7:0] e,
                          input bit push, input bit lat);
        int t;
        t = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_mask  = m;
        @(negedge clk);
        while (!a_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!a_in_ready) begin
            fail_evt("a_in_ready_timeout");
        end else begin
            if (push) q_a.push_back('{data: e, fire_cyc: cyc, chk_lat: lat});
            n_acc_a++;
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 32'hDEAD_BEEF;
        a_in_mask  = 4'hF;
    endtask

    task automatic send_b(input logic [39:0] d, input logic [4:0] m, input logic [7:0] e);
        int t;
        t = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_mask  = m;
        @(negedge clk);
        while (!b_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b_in_ready) fail_evt("b_in_ready_timeout");
        else q_b.push_back('{data: e, fire_cyc: cyc, chk_lat: 1'b1});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = 40'hA5_5A5A_A5A5;
        b_in_mask  = 5'h1F;
    endtask

    task automatic drain(input bit which_b);
        int t;
        t = 0;
        while (((which_b ? q_b.size() : q_a.size()) != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_evt(which_b ? "b_drain_timeout" : "a_drain_timeout");
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                fail_evt("a_unexpected_output");
            end else begin
                ea = q_a.pop_front();
                check("a_out_data", {24'h0, a_out_data}, {24'h0, ea.data});
                check("a_out_any", {31'h0, a_out_any}, {31'h0, |ea.data});
                if (ea.chk_lat) check("a_latency", cyc - ea.fire_cyc, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                fail_evt("b_unexpected_output");
            end else begin
                eb = q_b.pop_front();
                check("b_out_data", {24'h0, b_out_data}, {24'h0, eb.data});
                check("b_out_any", {31'h0, b_out_any}, {31'h0, |eb.data});
                if (eb.chk_lat) check("b_latency", cyc - eb.fire_cyc, 2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_out_valid", {31'h0, a_out_valid}, 0);
        check("rst_a_out_data", {24'h0, a_out_data}, 0);
        check("rst_a_out_any", {31'h0, a_out_any}, 0);
        check("rst_a_acc", {24'h0, a_acc_data}, 0);
        check("rst_b_out_valid", {31'h0, b_out_valid}, 0);
        check("rst_b_acc", {24'h0, b_acc_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_in_ready", {31'h0, a_in_ready}, 1);
        check("rst_b_in_ready", {31'h0, b_in_ready}, 1);
        @(posedge clk);
        #1;

        // basic reduction and masking
        send_a(32'h80_04_20_01, 4'b1111, 8'hA5, 1'b1, 1'b1);
        send_a(32'h80_04_20_01, 4'b0101, 8'h05, 1'b1, 1'b1);
        send_a(32'h80_04_20_01, 4'b0000, 8'h00, 1'b1, 1'b1);
        drain(1'b0);
        check("acc_after_basic", {24'h0, a_acc_data}, 32'hA5);

        // accumulator
        a_acc_clr = 1'b1;
        @(posedge clk);
        #1;
        a_acc_clr = 1'b0;
        @(negedge clk);
        check("acc_clr_alone_1", {24'h0, a_acc_data}, 0);
        @(posedge clk);
        #1;
        send_a(32'h00_00_00_01, 4'b1111, 8'h01, 1'b1, 1'b1);
        send_a(32'h00_10_00_00, 4'b1111, 8'h10, 1'b1, 1'b1);
        drain(1'b0);
        check("acc_accumulate", {24'h0, a_acc_data}, 32'h11);
        a_out_ready = 1'b0;
        send_a(32'h40_00_00_00, 4'b1111, 8'h40, 1'b1, 1'b0);
        t = 0;
        while (!a_out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!a_out_valid) fail_evt("acc_wait_out_valid_timeout");
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        a_acc_clr   = 1'b1;
        @(posedge clk);
        #1;
        a_acc_clr = 1'b0;
        @(negedge clk);
        check("acc_clr_with_fire", {24'h0, a_acc_data}, 32'h40);
        @(posedge clk);
        #1;
        a_acc_clr = 1'b1;
        @(posedge clk);
        #1;
        a_acc_clr = 1'b0;
        @(negedge clk);
        check("acc_clr_alone_2", {24'h0, a_acc_data}, 0);
        @(posedge clk);
        #1;

        // backpressure
        a_out_ready = 1'b0;
        n_acc_a     = 0;
        drv_done    = 1'b0;
        fork
            begin
                send_a(32'h00_00_00_01, 4'b1111, 8'h01, 1'b1, 1'b0);
                send_a(32'h00_00_02_00, 4'b1111, 8'h02, 1'b1, 1'b0);
                send_a(32'h00_04_00_00, 4'b1111, 8'h04, 1'b1, 1'b0);
                send_a(32'h08_00_00_00, 4'b1111, 8'h08, 1'b1, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        repeat (5) begin
            @(negedge clk);
            if (a_out_valid) check("bp_hold_data", {24'h0, a_out_data}, 32'h01);
        end
        check("bp_accepted", n_acc_a, 2);
        check("bp_in_ready_low", {31'h0, a_in_ready}, 0);
        check("bp_out_valid", {31'h0, a_out_valid}, 1);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        t = 0;
        while ((!drv_done || q_a.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_evt("bp_drain_timeout");
        check("bp_acc", {24'h0, a_acc_data}, 32'h0F);
        @(posedge clk);
        #1;

        // non-power-of-2 input count
        send_b(40'hFF_0000_0000, 5'b11111, 8'hFF);
        send_b(40'hF0_0000_0300, 5'b01111, 8'h03);
        send_b(40'hFF_FFFF_FFFF, 5'b00000, 8'h00);
        drain(1'b1);
        check("b_acc", {24'h0, b_acc_data}, 32'hFF);

        // reset with two beats in flight
        a_out_ready = 1'b0;
        send_a(32'h00_00_00_02, 4'b1111, 8'h02, 1'b0, 1'b0);
        send_a(32'h80_00_00_00, 4'b1111, 8'h80, 1'b0, 1'b0);
        check("mid_pre_out_valid", {31'h0, a_out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", {31'h0, a_out_valid}, 0);
        check("mid_acc", {24'h0, a_acc_data}, 0);
        check("mid_b_acc", {24'h0, b_acc_data}, 0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (a_out_valid) fail_evt("mid_stale_beat");
        end
        check("mid_in_ready", {31'h0, a_in_ready}, 1);
        check("mid_queue_empty", q_a.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
